range_converter: RTL and testbench

// - Linearly rescales an unsigned input from [g_Old_Min,g_Old_Max] to [g_New_Min,g_New_Max]:
//   new = g_New_Min + ((clamp(old) - g_Old_Min) * (g_New_Max - g_New_Min)) / (g_Old_Max - g_Old_Min).
// - Free-running: repeatedly samples i_Old_Value, divides with an internal sequential divider, and

---
 rtl/range_conv_pkg.sv | 17 +
 rtl/range_converter_if.sv | 15 +
 rtl/range_divider.sv | 78 +++++++
 rtl/range_converter.sv | 109 ++++++++++
 tb/tb_range_converter.sv | 132 +++++++++++++
 5 files changed

// File: rtl/range_conv_pkg.sv
// range_conv_pkg: shared types and helpers for the range converter.
//   conv_state_e : converter FSM states (IDLE -> LOAD -> DIVIDE -> DONE)
//   span()       : width of a closed range expressed as hi - lo
package range_conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_DIVIDE = 2'd2,
      ST_DONE   = 2'd3
   } conv_state_e;

   function automatic int unsigned span(input int unsigned hi, input int unsigned lo);
      return hi - lo;
   endfunction

endpackage

// File: rtl/range_converter_if.sv
// range_converter_if: value-in / value-out bundle around a range converter.
//   Old_Value : raw value to convert        (master -> slave)
//   New_Value : rescaled registered value   (slave -> master)
//   Valid     : one-cycle update pulse      (slave -> master)
interface range_converter_if #(
   parameter int unsigned g_Old_Width = 8,
   parameter int unsigned g_New_Width = 4
);
   logic [g_Old_Width-1:0] Old_Value;
   logic [g_New_Width-1:0] New_Value;
   logic                   Valid;

   modport master (output Old_Value, input New_Value, input Valid);
   modport slave  (input Old_Value, output New_Value, output Valid);
endinterface

// File: rtl/range_divider.sv
// range_divider: sequential restoring divider, one quotient bit per clock, MSB first.
//   i_Clk, i_Rst_L : clock, async active-low reset
//   i_Start        : load dividend/divisor and begin (takes priority over a running division)
//   i_Dividend     : numerator,   g_Div_Width bits
//   i_Divisor      : denominator, g_Div_Width bits, must be non-zero
//   o_Quotient     : result of the final step, valid while o_Done is high
//   o_Done         : high during the last of the g_Div_Width step cycles
module range_divider #(
   parameter int unsigned g_Div_Width = 12
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic                   i_Start,
   input  logic [g_Div_Width-1:0] i_Dividend,
   input  logic [g_Div_Width-1:0] i_Divisor,
   output logic [g_Div_Width-1:0] o_Quotient,
   output logic                   o_Done
);
   localparam int unsigned W     = g_Div_Width;
   localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

   logic [W-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [W:0]       shifted, trial;
   logic             q_bit, last;
   logic [W-1:0]     step_quo;

   always_comb begin
      // Shift next dividend bit into the partial remainder, then trial-subtract.
      shifted  = {rem_q, quo_q[W-1]};
      trial    = shifted - {1'b0, dvs_q};
      q_bit    = ~trial[W];
      step_quo = {quo_q[W-2:0], q_bit};
      last     = busy_q && (cnt_q == CNT_W'(W-1));

      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (i_Start) begin
         rem_d  = '0;
         quo_d  = i_Dividend;
         dvs_d  = i_Divisor;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Remainder is always < divisor, so W bits hold it.
         rem_d = q_bit ? trial[W-1:0] : shifted[W-1:0];
         quo_d = step_quo;
         cnt_d = cnt_q + CNT_W'(1);
         if (last) busy_d = 1'b0;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   // Final quotient is taken straight from the last step so the caller can
   // register it on the same edge that ends the division.
   assign o_Quotient = step_quo;
   assign o_Done     = last;

endmodule

// File: rtl/range_converter.sv
// range_converter: free-running linear rescale of i_Old_Value from
// [g_Old_Min,g_Old_Max] to [g_New_Min,g_New_Max] using a sequential divider.
//   i_Clk       : clock, rising edge
//   i_Rst_L     : async active-low reset
//   i_Old_Value : value to convert, sampled only in LOAD
//   o_New_Value : converted value, registered, updated on entry to DONE
//   o_Valid     : high for the single DONE cycle of each conversion
// Optional macro RANGE_CONV_ROUND_EN: adds half the old span to the dividend
// for round-half-up instead of truncation.
module range_converter
   import range_conv_pkg::*;
#(
   parameter int unsigned g_Old_Max   = 100,
   parameter int unsigned g_Old_Min   = 10,
   parameter int unsigned g_New_Max   = 15,
   parameter int unsigned g_New_Min   = 0,
   parameter int unsigned g_Old_Width = 8,
   parameter int unsigned g_New_Width = 4,
   parameter int unsigned g_Div_Width = 12
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic [g_Old_Width-1:0] i_Old_Value,
   output logic [g_New_Width-1:0] o_New_Value,
   output logic                   o_Valid
);
   localparam int unsigned OLD_SPAN = span(g_Old_Max, g_Old_Min);
   localparam int unsigned NEW_SPAN = span(g_New_Max, g_New_Min);
   localparam logic [g_Old_Width-1:0] OLD_MIN_W = g_Old_Width'(g_Old_Min);
   localparam logic [g_Old_Width-1:0] OLD_MAX_W = g_Old_Width'(g_Old_Max);

   if (g_Old_Max <= g_Old_Min) begin : g_chk_old
      $error("range_converter: g_Old_Max must exceed g_Old_Min");
   end
   if (g_New_Max < g_New_Min) begin : g_chk_new
      $error("range_converter: g_New_Max must be >= g_New_Min");
   end
   if (g_New_Max >= (64'd1 << g_New_Width)) begin : g_chk_new_w
      $error("range_converter: g_New_Max does not fit g_New_Width");
   end
   if ((64'(OLD_SPAN) * 64'(NEW_SPAN) + 64'(OLD_SPAN / 2)) >= (64'd1 << g_Div_Width)) begin : g_chk_div_w
      $error("range_converter: g_Div_Width too narrow for span product");
   end

   conv_state_e state_q, state_d;
   logic [g_New_Width-1:0] new_value_q, new_value_d;
   logic [g_Old_Width-1:0] clamped, offset;
   logic [g_Div_Width-1:0] dividend, div_quot;
   logic                   div_start, div_done;

   // Clamp first so out-of-range inputs saturate rather than wrap.
   always_comb begin
      clamped = i_Old_Value;
      if (i_Old_Value < OLD_MIN_W)      clamped = OLD_MIN_W;
      else if (i_Old_Value > OLD_MAX_W) clamped = OLD_MAX_W;
      offset   = clamped - OLD_MIN_W;
`ifdef RANGE_CONV_ROUND_EN
      dividend = g_Div_Width'(offset) * g_Div_Width'(NEW_SPAN) + g_Div_Width'(OLD_SPAN / 2);
`else
      dividend = g_Div_Width'(offset) * g_Div_Width'(NEW_SPAN);
`endif
   end

   range_divider #(.g_Div_Width(g_Div_Width)) u_div (
      .i_Clk      (i_Clk),
      .i_Rst_L    (i_Rst_L),
      .i_Start    (div_start),
      .i_Dividend (dividend),
      .i_Divisor  (g_Div_Width'(OLD_SPAN)),
      .o_Quotient (div_quot),
      .o_Done     (div_done)
   );

   // State register
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q     <= ST_IDLE;
         new_value_q <= g_New_Width'(g_New_Min);
      end else begin
         state_q     <= state_d;
         new_value_q <= new_value_d;
      end
   end

   // Next state
   always_comb begin
      state_d     = state_q;
      new_value_d = new_value_q;
      case (state_q)
         ST_IDLE:   state_d = ST_LOAD;
         ST_LOAD:   state_d = ST_DIVIDE;
         ST_DIVIDE: if (div_done) begin
                       state_d     = ST_DONE;
                       new_value_d = g_New_Width'(div_quot + g_Div_Width'(g_New_Min));
                    end
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      div_start = (state_q == ST_LOAD);
      o_Valid   = (state_q == ST_DONE);
   end

   assign o_New_Value = new_value_q;

endmodule

// File: tb/tb_range_converter.sv
// tb_range_converter: table-driven directed check of range_converter at default
// parameters (old 10..100, new 0..15, divider width 12), plus hand sequences for
// mid-division input change and mid-division reset.
module tb_range_converter;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   range_converter_if #(.g_Old_Width(8), .g_New_Width(4)) bus ();

   range_converter dut (
      .i_Clk       (clk),
      .i_Rst_L     (rst_n),
      .i_Old_Value (bus.Old_Value),
      .o_New_Value (bus.New_Value),
      .o_Valid     (bus.Valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] in_val;
      int         exp_trunc;
      int         exp_round;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Rising edges (sampled 1 ns after) until o_Valid is seen; bounded.
   task automatic wait_valid(input string name, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!bus.Valid && cyc < 40);
      if (!bus.Valid) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no o_Valid within %0d clocks", name, cyc);
      end
   endtask

   function automatic int expv(input vec_t v);
`ifdef RANGE_CONV_ROUND_EN
      return v.exp_round;
`else
      return v.exp_trunc;
`endif
   endfunction

   initial begin
      int c;
      // (clamp(x)-10)*15/90, and with +45 for rounding
      vecs[0]  = '{"in70",  8'd70,  10, 10};  // 900
      vecs[1]  = '{"in10",  8'd10,  0,  0};
      vecs[2]  = '{"in100", 8'd100, 15, 15};  // 1350
      vecs[3]  = '{"in5",   8'd5,   0,  0};
      vecs[4]  = '{"in200", 8'd200, 15, 15};
      vecs[5]  = '{"in13",  8'd13,  0,  1};   // 45 / 90
      vecs[6]  = '{"in55",  8'd55,  7,  8};   // 675 / 90
      vecs[7]  = '{"in0",   8'd0,   0,  0};
      vecs[8]  = '{"in255", 8'd255, 15, 15};
      vecs[9]  = '{"in11",  8'd11,  0,  0};   // 15 / 90
      vecs[10] = '{"in40",  8'd40,  5,  5};   // 450 / 90
      vecs[11] = '{"in98",  8'd98,  14, 15};  // 1320 / 90

      rst_n = 1'b0;
      bus.Old_Value = 8'd70;
      repeat (3) @(posedge clk);
      #1;
      check("reset value", int'(bus.New_Value), 0);
      check("reset valid", int'(bus.Valid), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Held value, 100 clocks, then must read 900/90
      repeat (100) @(posedge clk);
      wait_valid("hold70", c);
      check("hold70 value", int'(bus.New_Value), 10);

      foreach (vecs[i]) begin
         @(negedge clk);
         bus.Old_Value = vecs[i].in_val;
         wait_valid(vecs[i].name, c);  // may still carry the previous sample
         wait_valid(vecs[i].name, c);
         check({vecs[i].name, " value"}, int'(bus.New_Value), expv(vecs[i]));
         check({vecs[i].name, " period"}, c, 15);
      end

      // Input changes while dividing: current conversion unaffected
      @(negedge clk);
      bus.Old_Value = 8'd70;
      wait_valid("chg sync", c);
      wait_valid("chg sync", c);
      repeat (5) @(negedge clk);   // now inside DIVIDE with 70 sampled
      bus.Old_Value = 8'd100;
      wait_valid("chg first", c);
      check("chg first value", int'(bus.New_Value), 10);
      wait_valid("chg second", c);
      check("chg second value", int'(bus.New_Value), 15);

      // Reset in the middle of a division
      wait_valid("rst sync", c);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst value", int'(bus.New_Value), 0);
      check("midrst valid", int'(bus.Valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_valid("post rst", c);
      check("post rst latency", c, 14);
      check("post rst value", int'(bus.New_Value), 15);
      @(posedge clk);
      #1;
      check("post rst pulse width", int'(bus.Valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
